// File: rtl/dm_lsu_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dm_lsu_mem: byte-addressable data memory, valid/ready request channel, |
// | one-entry registered response. Macro: DM_MISALIGN_TRAP_EN.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dm_lsu_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF   = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   // Zero at time 0 only; reset never touches the array.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   logic              rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic              w_accept, w_illegal, w_err, w_we, w_sign;
   logic [IDX_W-1:0]  w_idx;
   logic [OFF-1:0]    w_off, w_lowmask;
   logic [3:0]        w_nbytes;
   logic [DATA_W-1:0] w_word, w_shift, w_ld, w_wsh;
   logic [NB-1:0]     w_be;

   assign req_ready = !rsp_valid_q || rsp_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   always_comb begin
      w_accept  = req_valid && req_ready;
      w_idx     = req_addr[IDX_W+OFF-1:OFF];
      w_nbytes  = 4'd1 << req_size;
      w_lowmask = OFF'(w_nbytes - 4'd1);
      w_illegal = (DATA_W == 32) && (req_size == 2'd3);
`ifdef DM_MISALIGN_TRAP_EN
      w_off     = req_addr[OFF-1:0];
      w_err     = w_illegal || ((w_off & w_lowmask) != '0);
`else
      w_off     = req_addr[OFF-1:0] & ~w_lowmask;
      w_err     = w_illegal;
`endif
      w_word  = mem_q[w_idx];
      w_shift = w_word >> {w_off, 3'b000};
      w_wsh   = req_wdata << {w_off, 3'b000};
      w_we    = w_accept && req_we && !w_err && rst_n;
      // Bytes are visited low to high, so w_sign ends as the MSB of the top kept byte.
      w_sign  = 1'b0;
      w_ld    = '0;
      for (int b = 0; b < NB; b++) begin
         w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + int'(w_nbytes));
         if (b < int'(w_nbytes)) begin
            w_ld[8*b +: 8] = w_shift[8*b +: 8];
            w_sign         = w_shift[8*b+7];
         end else begin
            w_ld[8*b +: 8] = {8{w_sign && !req_unsigned}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else if (w_accept) begin
         rsp_valid_q <= 1'b1;
         rsp_err_q   <= w_err;
         rsp_rdata_q <= (req_we || w_err) ? '0 : w_ld;
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   generate
      if (ADDR_W > IDX_W + OFF) begin : g_unused_addr
         logic w_unused_addr;
         assign w_unused_addr = ^req_addr[ADDR_W-1:IDX_W+OFF];
      end
   endgenerate
endmodule
`default_nettype wire
